// File: rtl/spi_segment_receiver.sv
// SPI mode-0 register slave feeding the segment output stage; pins oversampled in clk, build option SPI_SEG_READBACK_EN.
// Latency: an SCLK/CS_N edge first captured at clk edge n is acted on at edge n+2 (register write + wr_strobe together).
// Backpressure: none; the external master must respect the SCLK high/low and CS_N setup/hold minimums.
module spi_segment_receiver #(
    parameter logic [7:0] ID_VALUE      = 8'hA5,
    parameter logic [7:0] BLINK_DIV_RST = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] seg_pattern,
    output logic       disp_en,
    output logic       blink_en,
    output logic [7:0] blink_div,
    output logic       wr_strobe,
    output logic [1:0] wr_addr,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, WAIT_CS = 2'd3} state_t;

    state_t     state, state_nxt;
    logic [2:0] sclk_sync, cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_rise, cs_rise, cs_fall, cs_high, mosi_bit;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic [7:0] rx_byte;
    logic [1:0] addr;
    logic       frame_start, frame_stop, bit_shift, addr_done, data_done, abort;

    // CS_N synchroniser resets low so a frame already in progress at reset is never mistaken for a new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b000;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk};
            cs_sync   <= {cs_sync[1:0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_high   = cs_sync[1];
    assign mosi_bit  = mosi_sync[1];
    assign rx_byte   = {shift_reg, mosi_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_CS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = ADDR;
            ADDR:    if (cs_rise) state_nxt = IDLE;
                     else if (sclk_rise && bit_cnt == 3'd7) state_nxt = DATA;
            DATA:    if (cs_rise) state_nxt = IDLE;
            WAIT_CS: if (cs_high) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        frame_stop  = 1'b0;
        bit_shift   = 1'b0;
        addr_done   = 1'b0;
        data_done   = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: frame_start = cs_fall;
            ADDR, DATA: begin
                if (cs_rise) begin
                    frame_stop = 1'b1;
                    abort      = (bit_cnt != 3'd0);
                end else if (sclk_rise) begin
                    bit_shift = 1'b1;
                    addr_done = (state == ADDR) && (bit_cnt == 3'd7);
                    data_done = (state == DATA) && (bit_cnt == 3'd7);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= 3'd0;
            shift_reg   <= 7'd0;
            addr        <= 2'd0;
            seg_pattern <= 8'h00;
            disp_en     <= 1'b0;
            blink_en    <= 1'b0;
            blink_div   <= BLINK_DIV_RST;
            wr_strobe   <= 1'b0;
            wr_addr     <= 2'd0;
            frame_err   <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= abort;
            if (frame_start || frame_stop) begin
                bit_cnt   <= 3'd0;
                shift_reg <= 7'd0;
            end else if (bit_shift) begin
                bit_cnt   <= bit_cnt + 3'd1;
                shift_reg <= rx_byte[6:0];
            end
            if (addr_done) begin
                addr <= rx_byte[1:0];
            end
            // Address 3 is the ID: not written, no strobe, but the burst pointer still advances.
            if (data_done) begin
                addr <= addr + 2'd1;
                if (addr != 2'd3) begin
                    wr_strobe <= 1'b1;
                    wr_addr   <= addr;
                end
                case (addr)
                    2'd0:    seg_pattern <= rx_byte;
                    2'd1:    {blink_en, disp_en} <= rx_byte[1:0];
                    2'd2:    blink_div <= rx_byte;
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_SEG_READBACK_EN
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic [7:0] tx_reg;
    logic       sclk_fall;

    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign rd_sel    = addr_done ? rx_byte[1:0] : addr + 2'd1;

    always_comb begin
        case (rd_sel)
            2'd0:    rd_data = seg_pattern;
            2'd1:    rd_data = {6'b0, blink_en, disp_en};
            2'd2:    rd_data = blink_div;
            default: rd_data = ID_VALUE;
        endcase
    end

    // The fall that follows a byte's last rise keeps the freshly loaded MSB on the pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_reg <= 8'h00;
        end else if (frame_start) begin
            tx_reg <= 8'h00;
        end else if (addr_done || data_done) begin
            tx_reg <= rd_data;
        end else if (sclk_fall && state == DATA && bit_cnt != 3'd0) begin
            tx_reg <= {tx_reg[6:0], 1'b0};
        end
    end

    assign spi_miso = (state == DATA) & tx_reg[7];
`else
    logic unused_id;
    assign unused_id = ^ID_VALUE;
    assign spi_miso  = 1'b0;
`endif

endmodule
